demux32_buf: RTL and testbench
==============================

Name: demux32_buf

Overview:
- Registered 1-to-2 demultiplexer with per-destination buffering; routing counterpart of the datapath 2:1 selectors.
- Accepts one WIDTH-bit word per cycle over a valid/ready handshake, tagged with a destination select.
- Queues each word in the FIFO of the chosen destination, then presents it on that destination's valid/ready output channel.
- Sits between a single producer (e.g. writeback/result bus) and two independent consumers.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per destination FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word will be accepted this cycle.
- in_sel  input  1  destination: 0 selects out0, 1 selects out1.
- in_data  input  WIDTH  word to route.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_ready  input  1  consumer 0 takes head.
- out0_data  output  WIDTH  out0 FIFO head.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_ready  input  1  consumer 1 takes head.
- out1_data  output  WIDTH  out1 FIFO head.
- out0_count  output  log2(DEPTH)+1  out0 occupancy.
- out1_count  output  log2(DEPTH)+1  out1 occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - All FIFO pointers and counts clear to 0 and storage clears to 0.
  - out0_valid=0, out1_valid=0, out*_data=0, out*_count=0.
  - in_ready follows the reset-time counts, so it is 1 (both FIFOs empty).
  - Reset asserted mid-transfer discards all queued words immediately; no partial state survives.
- in_ready is combinational:
  - in_ready = (in_sel ? out1_count : out0_count) != DEPTH.
  - It depends on in_sel and never on in_valid or out*_ready.
- Accept: when in_valid & in_ready at an edge, in_data is written to the tail of the FIFO chosen by in_sel and that count increments.
- Full FIFO blocks the push even if its consumer pops in the same cycle. There is no same-cycle full bypass.
- Pop: when outN_valid & outN_ready at an edge, the head advances and countN decrements.
- outN_ready while outN_valid=0 has no effect, and count never underflows.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on the same empty FIFO:
  - The pop is ignored because valid=0.
  - The push lands, giving count=1 next cycle.
- Latency:
  - A word accepted at edge k is visible on outN_data with outN_valid=1 after edge k.
  - One cycle of latency, with no combinational in-to-out path.
- outN_valid = (countN != 0).
- outN_data = storage[head]. It is stable while valid=1 and ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is a separate log2(DEPTH)+1-bit register.
- Per-destination order is preserved. There is no ordering guarantee between destinations.
- The two destinations are fully independent: a full out1 never blocks traffic to out0.
- Data is transported without modification.

Decomposition:
- Shared package:
  - WIDTH default.
  - Destination encodings DEST_OUT0=1'b0 and DEST_OUT1=1'b1.
  - The count-width function clog2(DEPTH)+1.
- One natural sub-module, demux_fifo:
  - Synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, push_data, full, pop, head_data, empty, count.
  - The top instantiates it twice and adds the push-steering and in_ready logic.

Test Plan:
- Reset then idle -> in_ready=1, out0_valid=out1_valid=0, counts 0, data 0.
- Push 0xDEADBEEF with sel=0, out0_ready=0 -> next cycle out0_valid=1, out0_data=0xDEADBEEF, out0_count=1; out1 untouched.
- Push 0x11, 0x22 to out0 with out0_ready=0 (DEPTH=2), then present sel=0 again:
  - in_ready=0 and out0_count=2.
  - Switching to sel=1 gives in_ready=1, and 0x33 lands in out1.
- Full out0 with out0_ready=1 and a third word offered in the same cycle -> third word is not accepted that cycle; 0x11 is popped; the word is accepted on the next cycle; pop order is 0x11, 0x22, third.
- Continuous stream 0x1..0x8 with alternating sel and both readys=1 -> out0 sees 0x1, 0x3, 0x5, 0x7 and out1 sees 0x2, 0x4, 0x6, 0x8, each one cycle after acceptance; counts never exceed 1; pointers wrap correctly.
- Assert reset asynchronously (between edges) with out0_count=2 and out1_count=1 -> all valid=0, counts=0, data=0 immediately; after release, a push 0xA5 to out1 appears as a fresh single entry.

Source files
------------

// File: rtl/demux32_buf_pkg.sv
// Shared definitions for the demux32_buf routing block.
//   DEFAULT_WIDTH : default data word width
//   DEST_OUT0/1   : in_sel encodings for the two destinations
//   cnt_width()   : occupancy counter width for a given FIFO depth
package demux32_buf_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic DEST_OUT0 = 1'b0;
    localparam logic DEST_OUT1 = 1'b1;

    // Count must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Synchronous single-clock FIFO used as a per-destination buffer.
//   clk, reset           : clock, asynchronous active-low reset
//   push, push_data      : write request and word (ignored while full)
//   full                 : count == DEPTH
//   pop                  : read request (ignored while empty)
//   head_data            : word at the head pointer
//   empty                : count == 0
//   count                : occupancy, 0..DEPTH
module demux_fifo
    import demux32_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    output logic                            full,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head_data,
    output logic                            empty,
    output logic [cnt_width(DEPTH)-1:0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    // No same-cycle bypass: a full FIFO refuses the push even if it pops.
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux32_buf.sv
// Registered 1-to-2 demultiplexer with a FIFO per destination.
//   clk, reset                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_sel/in_data : producer channel; in_sel picks out0 or out1
//   outN_valid/outN_ready/outN_data  : consumer channels, head of FIFO N
//   outN_count                       : occupancy of FIFO N
module demux32_buf
    import demux32_buf_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sel,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out0_valid,
    input  logic                        out0_ready,
    output logic [WIDTH-1:0]            out0_data,
    output logic                        out1_valid,
    input  logic                        out1_ready,
    output logic [WIDTH-1:0]            out1_data,
    output logic [cnt_width(DEPTH)-1:0] out0_count,
    output logic [cnt_width(DEPTH)-1:0] out1_count
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic accept;

    // Readiness tracks only the selected destination, so a full out1 never stalls out0.
    assign in_ready = (in_sel == DEST_OUT1) ? ~full1 : ~full0;
    assign accept   = in_valid & in_ready;
    assign push0    = accept & (in_sel == DEST_OUT0);
    assign push1    = accept & (in_sel == DEST_OUT1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .pop       (out0_ready),
        .head_data (out0_data),
        .empty     (empty0),
        .count     (out0_count)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .pop       (out1_ready),
        .head_data (out1_data),
        .empty     (empty1),
        .count     (out1_count)
    );

endmodule

// File: tb/tb_demux32_buf.sv
// Self-checking bench for demux32_buf: directed cases plus random traffic,
// compared against two queues modelling the destination buffers.
module tb_demux32_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CntW-1:0]  out0_count;
    logic [CntW-1:0]  out1_count;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    demux32_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
        check_eq("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
        check_eq("out0_count", 64'(out0_count), 64'(q0.size()));
        check_eq("out1_count", 64'(out1_count), 64'(q1.size()));
        if (q0.size() != 0) check_eq("out0_data", 64'(out0_data), 64'(q0[0]));
        if (q1.size() != 0) check_eq("out1_data", 64'(out1_data), 64'(q1[0]));
    endtask

    // One clock: drive inputs, check in_ready, advance the model over the edge, check outputs.
    task automatic cycle(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        logic exp_rdy, acc, p0, p1;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        #1;
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out0_valid"}, 64'(out0_valid), 64'd0);
        check_eq({tag, "_out1_valid"}, 64'(out1_valid), 64'd0);
        check_eq({tag, "_out0_count"}, 64'(out0_count), 64'd0);
        check_eq({tag, "_out1_count"}, 64'(out1_count), 64'd0);
        check_eq({tag, "_out0_data"},  64'(out0_data),  64'd0);
        check_eq({tag, "_out1_data"},  64'(out1_data),  64'd0);
        check_eq({tag, "_in_ready"},   64'(in_ready),   64'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        #3;
        check_reset_state("por");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Idle, then single push to out0.
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Fill out0, see backpressure, then steer to out1.
        cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'hBAD, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);

        // Full out0 popping while a third word is offered: not taken until next cycle.
        cycle(1'b1, 1'b0, 32'h44, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 32'h44, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Alternating stream with both consumers always ready.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, logic'((i - 1) % 2), WIDTH'(i), 1'b1, 1'b1);
            check_eq("stream_cnt0_le1", 64'(out0_count <= 1), 64'd1);
            check_eq("stream_cnt1_le1", 64'(out1_count <= 1), 64'd1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Asynchronous reset with data queued in both FIFOs.
        cycle(1'b1, 1'b0, 32'h51, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h52, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h61, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_sel   = 1'b0;
        #2 reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check_reset_state("async_rst");
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
        check_eq("fresh_out1_count", 64'(out1_count), 64'd1);
        check_eq("fresh_out1_data", 64'(out1_data), 64'hA5);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), $urandom,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
